// File: rtl/psum_accum_engine_if.sv
// Signal bundle between conv_pe, the partial-sum accumulator and the drain consumer.
// The master is the producer/consumer side; the slave is the engine.
interface psum_accum_engine_if #(
    parameter int W_SIZE = 9,
    parameter int TOUT   = 4,
    parameter int W_PSUM = 32,
    parameter int DEPTH  = 1024
);
    localparam int AW = $clog2(DEPTH);

    logic [W_SIZE-1:0]      cfg_width;
    logic [W_SIZE-1:0]      cfg_height;
    logic                   i_first_tile;
    logic                   i_last_tile;
    logic                   i_start;
    logic                   i_vld;
    logic [W_SIZE-1:0]      i_row;
    logic [W_SIZE-1:0]      i_col;
    logic [TOUT*W_PSUM-1:0] i_acc_flat;
    logic                   i_end;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_out_vld;
    logic                   i_out_rdy;
    logic [AW-1:0]          o_out_addr;
    logic [TOUT*W_PSUM-1:0] o_out_data;
    logic [TOUT-1:0]        o_ovf;
    logic                   o_err;

    modport master (
        output cfg_width, cfg_height, i_first_tile, i_last_tile, i_start,
               i_vld, i_row, i_col, i_acc_flat, i_end, i_out_rdy,
        input  o_busy, o_done, o_out_vld, o_out_addr, o_out_data, o_ovf, o_err
    );

    modport slave (
        input  cfg_width, cfg_height, i_first_tile, i_last_tile, i_start,
               i_vld, i_row, i_col, i_acc_flat, i_end, i_out_rdy,
        output o_busy, o_done, o_out_vld, o_out_addr, o_out_data, o_ovf, o_err
    );
endinterface

// File: rtl/psum_accum_engine.sv
// Read-modify-write partial-sum store with per-lane saturating adds and a
// valid/ready drain of the finished frame after the last input-channel tile.
module psum_accum_engine #(
    parameter int W_SIZE = 9,
    parameter int TOUT   = 4,
    parameter int W_PSUM = 32,
    parameter int DEPTH  = 1024
) (
    input logic clk,
    input logic rst,
    psum_accum_engine_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = 2 * W_SIZE;
    localparam int VW = TOUT * W_PSUM;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, ACC, FLUSH, DRAIN, DONE} state_t;
    state_t state;

    logic [W_SIZE-1:0] width_q;
    logic [W_SIZE-1:0] height_q;
    logic              first_q;
    logic              last_q;

    logic [VW-1:0] mem [DEPTH];
    logic [VW-1:0] rd_q;
    logic [AW-1:0] rd_addr;

    logic          s1_vld;
    logic [AW-1:0] s1_addr;
    logic [VW-1:0] s1_acc;
    logic          s2_vld;
    logic [AW-1:0] s2_addr;
    logic [VW-1:0] s2_sum;

    logic [CW-1:0] frame_size;
    logic [CW-1:0] next_addr;
    logic [CW-1:0] fetch_addr;
    logic          fetch_vld;
    logic          out_last;

    logic [CW-1:0] beat_addr;
    logic          beat_take;
    logic          beat_ok;
    logic          out_load;
    logic          fetch_adv;
    logic          more;

    logic [VW-1:0]           operand;
    logic [VW-1:0]           sum_vec;
    logic [TOUT-1:0]         lane_clamp;
    logic signed [W_PSUM:0]  wide;

    assign frame_size = CW'(width_q) * CW'(height_q);
    assign beat_addr  = CW'(bus.i_row) * CW'(width_q) + CW'(bus.i_col);
    assign beat_take  = (state == ACC) && bus.i_vld;
    assign beat_ok    = (bus.i_row < height_q) && (bus.i_col < width_q) &&
                        ({1'b0, beat_addr} < DEPTH_LIM);

    // The fetch slot frees up when its entry moves to the output register;
    // a stalled slot keeps re-reading its own address so rd_q stays valid.
    assign out_load  = fetch_vld && (!bus.o_out_vld || bus.i_out_rdy);
    assign fetch_adv = out_load || !fetch_vld;
    assign more      = next_addr < frame_size;
    assign rd_addr   = (state != DRAIN)     ? beat_addr[AW-1:0] :
                       (fetch_adv && more)  ? next_addr[AW-1:0] : fetch_addr[AW-1:0];

    // The sync read misses the write landing on the same edge, so a matching
    // address in S2 supplies the operand instead.
    always_comb begin
        operand    = (s2_vld && (s2_addr == s1_addr)) ? s2_sum : rd_q;
        sum_vec    = '0;
        lane_clamp = '0;
        wide       = '0;
        for (int g = 0; g < TOUT; g++) begin
            if (first_q) begin
                wide = {s1_acc[(g+1)*W_PSUM-1], s1_acc[(g+1)*W_PSUM-1 -: W_PSUM]};
            end else begin
                wide = {operand[(g+1)*W_PSUM-1], operand[(g+1)*W_PSUM-1 -: W_PSUM]} +
                       {s1_acc[(g+1)*W_PSUM-1], s1_acc[(g+1)*W_PSUM-1 -: W_PSUM]};
            end
            if (wide[W_PSUM] != wide[W_PSUM-1]) begin
                lane_clamp[g] = 1'b1;
                sum_vec[(g+1)*W_PSUM-1 -: W_PSUM] = wide[W_PSUM] ?
                    {1'b1, {(W_PSUM-1){1'b0}}} : {1'b0, {(W_PSUM-1){1'b1}}};
            end else begin
                sum_vec[(g+1)*W_PSUM-1 -: W_PSUM] = wide[W_PSUM-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s1_vld) mem[s1_addr] <= sum_vec;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            width_q        <= '0;
            height_q       <= '0;
            first_q        <= 1'b0;
            last_q         <= 1'b0;
            s1_vld         <= 1'b0;
            s1_addr        <= '0;
            s1_acc         <= '0;
            s2_vld         <= 1'b0;
            s2_addr        <= '0;
            s2_sum         <= '0;
            next_addr      <= '0;
            fetch_addr     <= '0;
            fetch_vld      <= 1'b0;
            out_last       <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_out_vld  <= 1'b0;
            bus.o_out_addr <= '0;
            bus.o_out_data <= '0;
            bus.o_ovf      <= '0;
            bus.o_err      <= 1'b0;
        end else begin
            s1_vld <= beat_take && beat_ok;
            if (beat_take && beat_ok) begin
                s1_addr <= beat_addr[AW-1:0];
                s1_acc  <= bus.i_acc_flat;
            end
            if (beat_take && !beat_ok) bus.o_err <= 1'b1;
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_addr   <= s1_addr;
                s2_sum    <= sum_vec;
                bus.o_ovf <= bus.o_ovf | lane_clamp;
            end
            bus.o_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        width_q    <= bus.cfg_width;
                        height_q   <= bus.cfg_height;
                        first_q    <= bus.i_first_tile;
                        last_q     <= bus.i_last_tile;
                        bus.o_ovf  <= '0;
                        bus.o_err  <= 1'b0;
                        bus.o_busy <= 1'b1;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    if (bus.i_end) state <= FLUSH;
                end
                FLUSH: begin
                    // Once S1 has committed its write, the store is final.
                    if (!s1_vld) begin
                        if (last_q && (frame_size != '0)) begin
                            next_addr     <= '0;
                            fetch_vld     <= 1'b0;
                            bus.o_out_vld <= 1'b0;
                            state         <= DRAIN;
                        end else begin
                            bus.o_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DRAIN: begin
                    if (fetch_adv) begin
                        fetch_vld <= more;
                        if (more) begin
                            fetch_addr <= next_addr;
                            next_addr  <= next_addr + CW'(1);
                        end
                    end
                    if (out_load) begin
                        bus.o_out_vld  <= 1'b1;
                        bus.o_out_addr <= fetch_addr[AW-1:0];
                        bus.o_out_data <= rd_q;
                        out_last       <= (fetch_addr == frame_size - CW'(1));
                    end else if (bus.i_out_rdy) begin
                        bus.o_out_vld <= 1'b0;
                    end
                    if (bus.o_out_vld && bus.i_out_rdy && out_last) begin
                        bus.o_out_vld <= 1'b0;
                        bus.o_done    <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psum_accum_engine.sv
// Directed and randomized passes through the accumulator, checked against a
// sequential per-entry reference store with clamped integer arithmetic.
module tb_psum_accum_engine;
    localparam int W_SIZE = 9;
    localparam int TOUT   = 4;
    localparam int W_PSUM = 32;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int VW     = TOUT * W_PSUM;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_accum_engine_if #(.W_SIZE(W_SIZE), .TOUT(TOUT), .W_PSUM(W_PSUM), .DEPTH(DEPTH)) bus ();

    psum_accum_engine #(.W_SIZE(W_SIZE), .TOUT(TOUT), .W_PSUM(W_PSUM), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int            row;
        int            col;
        logic [VW-1:0] acc;
    } beat_t;

    beat_t           beats[$];
    int              rdy_pat[$];
    logic [VW-1:0]   ref_mem [DEPTH];
    logic [TOUT-1:0] ref_ovf;
    logic            ref_err;
    int              checks = 0;
    int              errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec4(input logic [31:0] l0, input logic [31:0] l1,
                                           input logic [31:0] l2, input logic [31:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic addBeat(input int row, input int col, input logic [VW-1:0] acc);
        beat_t b;
        b.row = row;
        b.col = col;
        b.acc = acc;
        beats.push_back(b);
    endtask

    // Reference: each beat either lands in its entry (overwrite or clamped add) or is dropped.
    task automatic modelBeat(input beat_t b, input bit first, input int w, input int h);
        int     idx;
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< 31) - 1;
        lo = -(longint'(1) <<< 31);
        idx = b.row * w + b.col;
        if (b.row >= h || b.col >= w || idx >= DEPTH) begin
            ref_err = 1'b1;
            return;
        end
        for (int g = 0; g < TOUT; g++) begin
            s = longint'($signed(b.acc[g*W_PSUM +: W_PSUM]));
            if (!first) s = s + longint'($signed(ref_mem[idx][g*W_PSUM +: W_PSUM]));
            if (s > hi) begin s = hi; ref_ovf[g] = 1'b1; end
            if (s < lo) begin s = lo; ref_ovf[g] = 1'b1; end
            ref_mem[idx][g*W_PSUM +: W_PSUM] = s[31:0];
        end
    endtask

    task automatic sendPass(input bit first, input bit last, input int w, input int h);
        bus.cfg_width    = W_SIZE'(w);
        bus.cfg_height   = W_SIZE'(h);
        bus.i_first_tile = first;
        bus.i_last_tile  = last;
        bus.i_start      = 1'b1;
        tick();
        bus.i_start = 1'b0;
        checkOutput("start_busy", bus.o_busy, 1);
        checkOutput("start_ovf_clear", bus.o_ovf, 0);
        checkOutput("start_err_clear", bus.o_err, 0);
        ref_ovf = '0;
        ref_err = 1'b0;
        for (int k = 0; k < beats.size(); k++) begin
            bus.i_vld      = 1'b1;
            bus.i_row      = W_SIZE'(beats[k].row);
            bus.i_col      = W_SIZE'(beats[k].col);
            bus.i_acc_flat = beats[k].acc;
            bus.i_end      = (k == beats.size() - 1);
            tick();
            modelBeat(beats[k], first, w, h);
        end
        if (beats.size() == 0) begin
            bus.i_end = 1'b1;
            tick();
        end
        bus.i_vld = 1'b0;
        bus.i_end = 1'b0;
        beats.delete();
    endtask

    task automatic drainAndFinish(input int w, input int h, input bit last);
        int            expect_addr;
        int            done_count;
        int            tail;
        bit            held;
        logic [AW-1:0] held_addr;
        logic [VW-1:0] held_data;
        expect_addr = 0;
        done_count  = 0;
        tail        = 0;
        held        = 1'b0;
        held_addr   = '0;
        held_data   = '0;
        for (int cyc = 0; cyc < 600 && tail < 3; cyc++) begin
            if (bus.o_done) done_count++;
            if (done_count > 0) tail++;
            bus.i_out_rdy = rdy_pat[cyc % rdy_pat.size()] != 0;
            if (bus.o_out_vld) begin
                if (held) begin
                    checkOutput("stall_addr", bus.o_out_addr, held_addr);
                    checkOutput("stall_data", bus.o_out_data, held_data);
                end
                if (bus.i_out_rdy) begin
                    checkOutput("drain_addr", bus.o_out_addr, expect_addr[AW-1:0]);
                    checkOutput("drain_data", bus.o_out_data, ref_mem[expect_addr % DEPTH]);
                    expect_addr++;
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    held_addr = bus.o_out_addr;
                    held_data = bus.o_out_data;
                end
            end
            tick();
        end
        bus.i_out_rdy = 1'b0;
        checkOutput("done_pulses", done_count, 1);
        checkOutput("drain_beats", expect_addr, last ? w * h : 0);
        checkOutput("busy_after", bus.o_busy, 0);
        checkOutput("ovf_flags", bus.o_ovf, ref_ovf);
        checkOutput("err_flag", bus.o_err, ref_err);
    endtask

    task automatic applyStimulus(input bit first, input bit last, input int w, input int h);
        sendPass(first, last, w, h);
        drainAndFinish(w, h, last);
    endtask

    task automatic fillFrame(input int w, input int h, input bit rnd, input logic [VW-1:0] val);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++)
                addBeat(r, c, rnd ? {$urandom, $urandom, $urandom, $urandom} : val);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int w;
        int h;
        int n;
        rst              = 1'b1;
        bus.cfg_width    = '0;
        bus.cfg_height   = '0;
        bus.i_first_tile = 1'b0;
        bus.i_last_tile  = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_vld        = 1'b0;
        bus.i_row        = '0;
        bus.i_col        = '0;
        bus.i_acc_flat   = '0;
        bus.i_end        = 1'b0;
        bus.i_out_rdy    = 1'b0;
        rdy_pat          = '{1};
        repeat (3) tick();
        checkOutput("reset_busy", bus.o_busy, 0);
        checkOutput("reset_done", bus.o_done, 0);
        checkOutput("reset_vld", bus.o_out_vld, 0);
        checkOutput("reset_ovf", bus.o_ovf, 0);
        checkOutput("reset_err", bus.o_err, 0);
        rst = 1'b0;
        tick();

        $display("[TB] 2x2 single-tile pass");
        for (int a = 0; a < 4; a++) addBeat(a / 2, a % 2, vec4(1*(a+1), 2*(a+1), 3*(a+1), 4*(a+1)));
        applyStimulus(1, 1, 2, 2);

        $display("[TB] two tiles, 5 then -7");
        fillFrame(4, 4, 0, vec4(5, 5, 5, 5));
        applyStimulus(1, 0, 4, 4);
        fillFrame(4, 4, 0, vec4(-7, -7, -7, -7));
        applyStimulus(0, 1, 4, 4);

        $display("[TB] back-to-back same entry");
        addBeat(0, 0, vec4(10, 10, 10, 10));
        applyStimulus(1, 0, 1, 1);
        addBeat(0, 0, vec4(1, 1, 1, 1));
        addBeat(0, 0, vec4(2, 2, 2, 2));
        addBeat(0, 0, vec4(3, 3, 3, 3));
        applyStimulus(0, 1, 1, 1);

        $display("[TB] lane saturation");
        addBeat(0, 0, vec4(32'h7FFFFFF0, 100, -5, 0));
        applyStimulus(1, 0, 1, 1);
        addBeat(0, 0, vec4(32'h20, 1, 1, 32'h80000000));
        applyStimulus(0, 1, 1, 1);

        $display("[TB] zero-size frame");
        applyStimulus(1, 1, 0, 3);

        $display("[TB] drain with ready toggling");
        rdy_pat = '{1, 0, 0, 1};
        fillFrame(3, 3, 1, '0);
        applyStimulus(1, 1, 3, 3);
        rdy_pat = '{1};

        $display("[TB] out-of-range beat");
        fillFrame(3, 3, 1, '0);
        addBeat(3, 0, vec4(9, 9, 9, 9));
        applyStimulus(1, 1, 3, 3);

        $display("[TB] reset during drain");
        fillFrame(3, 3, 1, '0);
        sendPass(1, 1, 3, 3);
        bus.i_out_rdy = 1'b0;
        for (int k = 0; k < 20 && !bus.o_out_vld; k++) tick();
        checkOutput("rst_reached_drain", bus.o_out_vld, 1);
        rst = 1'b1;
        tick();
        checkOutput("rst_vld", bus.o_out_vld, 0);
        checkOutput("rst_busy", bus.o_busy, 0);
        checkOutput("rst_done", bus.o_done, 0);
        rst = 1'b0;
        tick();
        fillFrame(2, 2, 1, '0);
        applyStimulus(1, 1, 2, 2);

        $display("[TB] randomized multi-tile passes");
        for (int it = 0; it < 3; it++) begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 8);
            fillFrame(w, h, 1, '0);
            applyStimulus(1, 0, w, h);
            n = 2 * w * h;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0)
                    addBeat($urandom_range(0, h - 1), w, {$urandom, $urandom, $urandom, $urandom});
                else
                    addBeat($urandom_range(0, h - 1), $urandom_range(0, w - 1),
                            {$urandom, $urandom, $urandom, $urandom});
            end
            rdy_pat.delete();
            for (int k = 0; k < 7; k++) rdy_pat.push_back(int'($urandom_range(0, 1)));
            rdy_pat.push_back(1);
            applyStimulus(0, 1, w, h);
            rdy_pat = '{1};
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
